// File: rtl/kyber_pkg.sv
// Shared Kyber constants, FSM encoding for the inverse-NTT sink and the
// conditional-subtract reduction also used by the invntt core.
package kyber_pkg;

  localparam int KYBER_DEPTH = 8;
  localparam int KYBER_Q     = 3329;
  localparam int COEF_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN
  } sink_state_e;

  // Single conditional subtract: values in [0, 2q) land in [0, q).
  function automatic logic [31:0] red_q(input logic [31:0] x, input logic [31:0] q);
    return (x >= q) ? x - q : x;
  endfunction

endpackage

// File: rtl/invntt_sink_if.sv
// Pair-input and coefficient-output streams of the inverse-NTT sink.
interface invntt_sink_if
  import kyber_pkg::*;
#(
  parameter int DEPTH = KYBER_DEPTH,
  parameter int WIDTH = COEF_W
);

  logic             in_valid;
  logic [WIDTH-1:0] din_1;
  logic [WIDTH-1:0] din_2;
  logic [DEPTH-1:0] in_index;
  logic             in_last;
  logic             in_ready;

  logic [WIDTH-1:0] dout;
  logic [DEPTH-1:0] out_addr;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_valid, din_1, din_2, in_index, in_last, out_ready,
    output in_ready, dout, out_addr, out_valid, out_last
  );

  modport master (
    output in_valid, din_1, din_2, in_index, in_last, out_ready,
    input  in_ready, dout, out_addr, out_valid, out_last
  );

endinterface

// File: rtl/poly_bank.sv
// One polynomial bank: 1 write / 1 read port, synchronous read.
module poly_bank #(
  parameter int AW    = 7,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // NOTE: the array and its read register have no reset so they map onto
  // block RAM; contents are undefined until written.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/invntt_sink.sv
// Collects inverse-NTT coefficient pairs into even/odd banks, then drains the
// polynomial in natural order over a valid/ready stream with optional mod-q fix-up.
module invntt_sink
  import kyber_pkg::*;
#(
  parameter int DEPTH  = KYBER_DEPTH,
  parameter int WIDTH  = COEF_W,
  parameter int Q      = KYBER_Q,
  parameter int REDUCE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             err,
  invntt_sink_if.slave     bus
);

  localparam int N    = 1 << DEPTH;
  localparam int ROWS = N / 2;
  localparam int RW   = DEPTH - 1;

  sink_state_e state, state_nxt;

  logic [ROWS-1:0]  bitmap;
  logic [DEPTH-1:0] pair_cnt;
  logic             err_q;

  logic             xfer, odd_idx, wr_en, dup, cap_exit;
  logic [RW-1:0]    wr_row;
  logic [DEPTH-1:0] cnt_nxt;

  logic [DEPTH:0]   rd_ptr;
  logic             issue, adv2, final_hs;
  logic             v1;
  logic [DEPTH-1:0] a1;
  logic [WIDTH-1:0] q_even, q_odd, raw, res;

  logic             ov_q, olast_q;
  logic [WIDTH-1:0] dout_q;
  logic [DEPTH-1:0] oaddr_q;

  // Capture decode: a pair at an odd base index is dropped, never written.
  always_comb begin
    xfer     = (state == ST_CAPTURE) && bus.in_valid;
    odd_idx  = bus.in_index[0];
    wr_row   = bus.in_index[DEPTH-1:1];
    wr_en    = xfer && !odd_idx;
    dup      = bitmap[wr_row];
    cnt_nxt  = pair_cnt + DEPTH'(wr_en && !dup);
    cap_exit = (state == ST_CAPTURE) && ((cnt_nxt == DEPTH'(ROWS)) || bus.in_last);
  end

  // Drain handshakes: output register loads when empty or being taken; the
  // RAM read register holds its word whenever no new read is issued.
  always_comb begin
    adv2     = !ov_q || bus.out_ready;
    issue    = (state == ST_DRAIN) && !rd_ptr[DEPTH] && (!v1 || adv2);
    final_hs = (state == ST_DRAIN) && ov_q && bus.out_ready && olast_q;
    raw      = a1[0] ? q_odd : q_even;
    res      = (REDUCE != 0) ? WIDTH'(red_q(32'(raw), 32'(Q))) : raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so every path assigns state_nxt (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start)    state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (cap_exit) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (final_hs) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ST_CAPTURE);
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap   <= '0;
      pair_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      bitmap   <= '0;
      pair_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      if (wr_en) bitmap[wr_row] <= 1'b1;
      pair_cnt <= cnt_nxt;
      if ((xfer && odd_idx) || (wr_en && dup) ||
          (cap_exit && (cnt_nxt != DEPTH'(ROWS))))
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      v1      <= 1'b0;
      a1      <= '0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
      dout_q  <= '0;
      oaddr_q <= '0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        v1     <= 1'b1;
        a1     <= rd_ptr[DEPTH-1:0];
      end else begin
        if (state == ST_IDLE) rd_ptr <= '0;
        if (v1 && adv2)       v1     <= 1'b0;
      end
      if (adv2) begin
        ov_q    <= v1;
        olast_q <= v1 && (a1 == DEPTH'(N - 1));
        if (v1) begin
          dout_q  <= res;
          oaddr_q <= a1;
        end
      end
    end
  end

  assign err           = err_q;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = olast_q;
  assign bus.dout      = dout_q;
  assign bus.out_addr  = oaddr_q;

  poly_bank #(.AW(RW), .WIDTH(WIDTH)) u_even (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_row),
    .wdata (bus.din_2),
    .re    (issue),
    .raddr (rd_ptr[DEPTH-1:1]),
    .rdata (q_even)
  );

  poly_bank #(.AW(RW), .WIDTH(WIDTH)) u_odd (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_row),
    .wdata (bus.din_1),
    .re    (issue),
    .raddr (rd_ptr[DEPTH-1:1]),
    .rdata (q_odd)
  );

endmodule
